// File: rtl/conv_arbiter.sv
// Round-robin arbiter sharing one soc/eoc converter among N requesters.
// Each grant runs soc/eoc, then returns the sampled byte over a 4-phase req/ack handshake.
module conv_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] ack_o,
  output logic [W-1:0] dout_o,
  output logic         err_o,
  output logic         soc_o,
  input  logic         eoc_i,
  input  logic [W-1:0] x_i
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  localparam logic [IW-1:0] G_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] g_q, g_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          soc_q, soc_d;
  logic          err_q, err_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  dout_q, dout_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [TW-1:0] timer_inc;
  logic [N-1:0]  g_onehot;
  logic [IW-1:0] g_next;

  // First set request at or above ptr, wrapping modulo N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_vld && req_i[(int'(ptr_q) + i) % N]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    g_onehot      = '0;
    g_onehot[g_q] = 1'b1;
  end

  assign g_next    = (g_q == G_LAST) ? '0 : g_q + IW'(1);
  assign timer_inc = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    timer_d = timer_q;
    soc_d   = soc_q;
    err_d   = err_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        // eoc=0 here means the converter is still busy from before a reset.
        if (eoc_i && pick_vld) begin
          g_d     = pick_idx;
          soc_d   = 1'b1;
          timer_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!eoc_i) begin
          soc_d   = 1'b0;
          timer_d = '0;
          state_d = S_WAIT;
        end else if (timer_q == T_LAST) begin
          soc_d   = 1'b0;
          ack_d   = g_onehot;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT: begin
        if (eoc_i) begin
          dout_d  = x_i;
          ack_d   = g_onehot;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timer_q == T_LAST) begin
          ack_d   = g_onehot;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_DONE: begin
        if (!req_i[g_q]) begin
          ack_d   = '0;
          err_d   = 1'b0;
          ptr_d   = g_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      timer_q <= '0;
      soc_q   <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      timer_q <= timer_d;
      soc_q   <= soc_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
    end
  end

  assign ack_o  = ack_q;
  assign dout_o = dout_q;
  assign err_o  = err_q;
  assign soc_o  = soc_q;

  a_ack_onehot: assert property (@(posedge clk_i) $onehot0(ack_q));

endmodule

// File: tb/tb_conv_arbiter.sv
// Scoreboard bench for conv_arbiter: directed requests, a behavioural converter,
// expected acks queued at stimulus time and checked by an independent monitor.
module tb_conv_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 20;

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] dout;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [W-1:0] dout;
  logic         err;
  logic         soc;
  logic         eoc;
  logic [W-1:0] x;
  logic         model_eoc;
  logic         hold_busy;
  logic         stuck;

  exp_t         exp_q[$];
  logic [W-1:0] xq[$];
  exp_t         e;
  logic [N-1:0] prev_ack;
  logic [N-1:0] got;
  int           cnt;
  int           checks;
  int           failures;

  assign eoc = model_eoc & ~hold_busy;

  conv_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .ack_o (ack),
    .dout_o(dout),
    .err_o (err),
    .soc_o (soc),
    .eoc_i (eoc),
    .x_i   (x)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [N-1:0] a, input logic [W-1:0] d, input logic er);
    exp_t r;
    r.ack  = a;
    r.dout = d;
    r.err  = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req_v);
    end
  endtask

  // which: 0 ack!=0, 1 ack==0, 2 soc==1, 3 soc==0
  task automatic wait_for(input string name, input int which);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok) begin
      case (which)
        0:       ok = (ack != '0);
        1:       ok = (ack == '0);
        2:       ok = soc;
        default: ok = !soc;
      endcase
      if (!ok) begin
        if (n >= 500) begin
          checks++;
          failures++;
          $display("FAIL %s: wait expired after %0d cycles", name, n);
          return;
        end
        @(negedge clk);
        n++;
      end
    end
  endtask

  // Converter: eoc drops 3 half-periods after soc rises; eoc and x return
  // 4 half-periods (+1 unit, off the clock edge) after soc falls.
  initial begin
    model_eoc = 1'b1;
    x         = '0;
    forever begin
      @(posedge soc);
      if (!stuck) begin
        #15 model_eoc = 1'b0;
        @(negedge soc);
        #21;
        if (xq.size() > 0) x = xq.pop_front();
        model_eoc = 1'b1;
      end
    end
  end

  // Monitor: each new ack is matched against the oldest expected response.
  initial begin
    prev_ack = '0;
    forever begin
      @(negedge clk);
      if (!rst && ack != '0 && prev_ack == '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack=%b dout=%0h with nothing expected", ack, dout);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ack", 32'(ack), 32'(e.ack));
          chk("sb_dout", 32'(dout), 32'(e.dout));
          chk("sb_err", 32'(err), 32'(e.err));
        end
      end
      prev_ack = ack;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req       = '0;
    hold_busy = 1'b0;
    stuck     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_soc", 32'(soc), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;

    // T1 single request
    xq.push_back(8'd8);
    exp_q.push_back(mk(4'b0001, 8'd8, 1'b0));
    req = 4'b0001;
    @(negedge clk);
    chk("t1_req_to_soc", 32'(soc), 1);
    wait_for("t1_ack", 0);
    req = '0;
    @(negedge clk);
    chk("t1_ack_drop", 32'(ack), 0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T2 round robin with all requesters active
    xq.push_back(8'd6);  exp_q.push_back(mk(4'b0001, 8'd6, 1'b0));
    xq.push_back(8'd14); exp_q.push_back(mk(4'b0010, 8'd14, 1'b0));
    xq.push_back(8'd13); exp_q.push_back(mk(4'b0100, 8'd13, 1'b0));
    xq.push_back(8'd25); exp_q.push_back(mk(4'b1000, 8'd25, 1'b0));
    xq.push_back(8'd36); exp_q.push_back(mk(4'b0001, 8'd36, 1'b0));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_for("t2_ack", 0);
      got = ack;
      if (i == 4) req = '0;
      else        req = req & ~got;
      wait_for("t2_release", 1);
      if (i < 3) req = req | got;
    end

    // T3 pointer: serve 2, then 3 outranks 0
    xq.push_back(8'h5A); exp_q.push_back(mk(4'b0100, 8'h5A, 1'b0));
    req = 4'b0100;
    wait_for("t3_ack2", 0);
    req = '0;
    wait_for("t3_rel2", 1);
    xq.push_back(8'h11); exp_q.push_back(mk(4'b1000, 8'h11, 1'b0));
    xq.push_back(8'h22); exp_q.push_back(mk(4'b0001, 8'h22, 1'b0));
    req = 4'b1001;
    wait_for("t3_ack3", 0);
    req = 4'b0001;
    wait_for("t3_rel3", 1);
    wait_for("t3_ack0", 0);
    req = '0;
    wait_for("t3_rel0", 1);

    // T4 watchdog: eoc never drops, dout keeps the previous result
    stuck = 1'b1;
    exp_q.push_back(mk(4'b0010, 8'h22, 1'b1));
    req = 4'b0010;
    wait_for("t4_soc_rise", 2);
    cnt = 0;
    while (soc && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_soc_cycles", 32'(cnt), TO);
    chk("t4_ack_at_abort", 32'(ack), 32'(4'b0010));
    req = '0;
    wait_for("t4_rel", 1);
    stuck = 1'b0;
    xq.push_back(8'h77); exp_q.push_back(mk(4'b0100, 8'h77, 1'b0));
    req = 4'b0100;
    wait_for("t4_ack_next", 0);
    req = '0;
    wait_for("t4_rel_next", 1);

    // T5 busy converter blocks start; reset mid-WAIT; restart afterwards
    hold_busy = 1'b1;
    req = 4'b0001;
    repeat (5) begin
      @(negedge clk);
      chk("t5_busy_soc", 32'(soc), 0);
    end
    xq.push_back(8'h3C);
    xq.push_back(8'h4D);
    exp_q.push_back(mk(4'b0001, 8'h4D, 1'b0));
    hold_busy = 1'b0;
    wait_for("t5_soc_rise", 2);
    wait_for("t5_soc_fall", 3);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_soc", 32'(soc), 0);
    chk("t5_rst_ack", 32'(ack), 0);
    chk("t5_rst_dout", 32'(dout), 0);
    chk("t5_rst_err", 32'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_for("t5_ack_restart", 0);
    req = '0;
    wait_for("t5_rel", 1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
